// File: rtl/ahbl_splitter_n.sv
// N-port AHB-Lite splitter: page decode, data-phase owner mux and a built-in
// two-cycle ERROR default slave. Optional stall watchdog via AHBL_SPLITTER_WDT_EN.
module ahbl_splitter_n #(
  parameter int unsigned       NS      = 4,
  parameter int unsigned       DW      = 32,
  parameter logic [NS*4-1:0]   S_PAGES = {4'hC, 4'h8, 4'h4, 4'h0},
  parameter int unsigned       TIMEOUT = 255
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic             HREADY,
  output logic             HRESP,
  output logic [DW-1:0]    HRDATA,
  output logic [NS-1:0]    S_HSEL,
  input  logic [NS*DW-1:0] S_HRDATA,
  input  logic [NS-1:0]    S_HREADYOUT,
  input  logic [NS-1:0]    S_HRESP,
  output logic             TO_FLAG,
  output logic [3:0]       TO_IDX,
  input  logic             TO_CLR
);

  typedef enum logic [1:0] {OWN_NONE, OWN_SLV, OWN_DEF} own_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_e;

  localparam logic [DW-1:0] BAD_DATA = DW'(32'hBADDBEEF);

  own_e          r_own;
  logic [3:0]    r_own_idx;
  err_e          r_st;

  logic [NS-1:0] w_hsel;
  logic          w_match;
  logic [3:0]    w_idx;
  logic          w_s_ready;
  logic          w_s_resp;
  logic [DW-1:0] w_s_data;
  logic          w_hready;
  logic          w_hresp;
  logic [DW-1:0] w_hrdata;
  logic          w_timeout;
  logic          w_unused;

  // Ascending scan with an early-match flag so the lowest index wins on duplicate pages.
  always_comb begin
    w_hsel  = '0;
    w_match = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!w_match && (HADDR[31:28] == S_PAGES[4*i +: 4])) begin
        w_match   = 1'b1;
        w_idx     = 4'(i);
        w_hsel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_s_ready = 1'b1;
    w_s_resp  = 1'b0;
    w_s_data  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (r_own_idx == 4'(i)) begin
        w_s_ready = S_HREADYOUT[i];
        w_s_resp  = S_HRESP[i];
        w_s_data  = S_HRDATA[DW*i +: DW];
      end
    end
  end

  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = BAD_DATA;
    unique case (r_own)
      OWN_SLV: begin
        w_hready = w_s_ready;
        w_hresp  = w_s_resp;
        w_hrdata = w_s_data;
      end
      OWN_DEF: begin
        w_hready = (r_st == ST_ERR2);
        w_hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  // A watchdog timeout hands the stalled data phase to the default slave.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_own     <= OWN_NONE;
      r_own_idx <= '0;
      r_st      <= ST_IDLE;
    end else if (w_timeout) begin
      r_own <= OWN_DEF;
      r_st  <= ST_ERR1;
    end else if (w_hready) begin
      if (!HTRANS[1]) begin
        r_own <= OWN_NONE;
        r_st  <= ST_IDLE;
      end else if (w_match) begin
        r_own     <= OWN_SLV;
        r_own_idx <= w_idx;
        r_st      <= ST_IDLE;
      end else begin
        r_own <= OWN_DEF;
        r_st  <= ST_ERR1;
      end
    end else if (r_st == ST_ERR1) begin
      r_st <= ST_ERR2;
    end
  end

`ifdef AHBL_SPLITTER_WDT_EN
  logic [15:0] r_cnt;
  logic        r_to_flag;
  logic [3:0]  r_to_idx;
  logic        w_stall;

  assign w_stall   = (r_own == OWN_SLV) && !w_s_ready;
  assign w_timeout = w_stall && (r_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_cnt     <= '0;
      r_to_flag <= 1'b0;
      r_to_idx  <= '0;
    end else begin
      if (w_timeout || w_hready) r_cnt <= '0;
      else if (w_stall)          r_cnt <= r_cnt + 16'd1;
      if (w_timeout) begin
        r_to_flag <= 1'b1;
        r_to_idx  <= r_own_idx;
      end else if (TO_CLR) begin
        r_to_flag <= 1'b0;
      end
    end
  end

  assign TO_FLAG  = r_to_flag;
  assign TO_IDX   = r_to_idx;
  assign w_unused = ^{HADDR[27:0], HTRANS[0]};
`else
  assign w_timeout = 1'b0;
  assign TO_FLAG   = 1'b0;
  assign TO_IDX    = '0;
  assign w_unused  = ^{HADDR[27:0], HTRANS[0], TO_CLR, 16'(TIMEOUT)};
`endif

  assign S_HSEL = w_hsel;
  assign HREADY = w_hready;
  assign HRESP  = w_hresp;
  assign HRDATA = w_hrdata;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: vector table plus hand sequences for
// reset-in-ERR1 and the stall watchdog (AHBL_SPLITTER_WDT_EN-aware).
module tb_ahbl_splitter_n;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [3:0]   S_HSEL;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HREADYOUT;
  logic [3:0]   S_HRESP;
  logic         TO_FLAG;
  logic [3:0]   TO_IDX;
  logic         TO_CLR;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [31:0] BAD    = 32'hBADDBEEF;

  ahbl_splitter_n #(
    .NS(4), .DW(32), .S_PAGES(16'hC840), .TIMEOUT(4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .S_HSEL(S_HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .TO_FLAG(TO_FLAG), .TO_IDX(TO_IDX), .TO_CLR(TO_CLR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  rdy;
    logic [3:0]  resp;
    logic [3:0]  hsel;
    logic        hready;
    logic        hresp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Each entry is one cycle: outputs reflect the owner from the previous address phase.
    vecs[0]  = '{32'h4000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, BAD};
    vecs[1]  = '{32'h7000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h12345678};
    vecs[2]  = '{32'h7000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, BAD};
    vecs[3]  = '{32'h9000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b1, BAD};
    vecs[4]  = '{32'h9000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, BAD};
    vecs[5]  = '{32'h0000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, BAD};
    vecs[6]  = '{32'h4000_0000, T_IDLE, 4'hD, 4'h0, 4'b0010, 1'b1, 1'b0, 32'hA0A0A0A0};
    vecs[7]  = '{32'h4000_0000, T_IDLE, 4'hD, 4'h0, 4'b0010, 1'b1, 1'b0, BAD};
    vecs[8]  = '{32'h8000_0000, T_NSEQ, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b0, BAD};
    vecs[9]  = '{32'hC000_0000, T_NSEQ, 4'hB, 4'h0, 4'b1000, 1'b0, 1'b0, 32'hC2C2C2C2};
    vecs[10] = '{32'hC000_0000, T_NSEQ, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, 32'hC2C2C2C2};
    vecs[11] = '{32'hC000_0000, T_IDLE, 4'h7, 4'h8, 4'b1000, 1'b0, 1'b1, 32'hD3D3D3D3};
    vecs[12] = '{32'hC000_0000, T_IDLE, 4'hF, 4'h8, 4'b1000, 1'b1, 1'b1, 32'hD3D3D3D3};
    vecs[13] = '{32'hF000_0000, T_IDLE, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, BAD};

    S_HRDATA    = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'h12345678, 32'hA0A0A0A0};
    S_HREADYOUT = 4'hF;
    S_HRESP     = 4'h0;
    TO_CLR      = 1'b0;
    HRESETn     = 1'b0;
    HADDR       = 32'h4000_0000;
    HTRANS      = T_IDLE;
    tick();
    tick();
    #3;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      BAD);
    chk("rst_hsel",   32'(S_HSEL), 32'h2);
    chk("rst_toflag", 32'(TO_FLAG), 32'd0);
    chk("rst_toidx",  32'(TO_IDX), 32'd0);
    HRESETn = 1'b1;
    tick();

    for (int v = 0; v < 14; v++) begin
      HADDR       = vecs[v].addr;
      HTRANS      = vecs[v].trans;
      S_HREADYOUT = vecs[v].rdy;
      S_HRESP     = vecs[v].resp;
      #3;
      chk($sformatf("v%0d_hsel", v),   32'(S_HSEL), 32'(vecs[v].hsel));
      chk($sformatf("v%0d_hready", v), 32'(HREADY), 32'(vecs[v].hready));
      chk($sformatf("v%0d_hresp", v),  32'(HRESP),  32'(vecs[v].hresp));
      chk($sformatf("v%0d_hrdata", v), HRDATA,      vecs[v].rdata);
      tick();
    end
    S_HREADYOUT = 4'hF;
    S_HRESP     = 4'h0;

    // Reset asserted while the default slave is in ERR1.
    HADDR  = 32'h7000_0000;
    HTRANS = T_NSEQ;
    #3;
    chk("rs_addr_hready", 32'(HREADY), 32'd1);
    tick();
    HRESETn = 1'b0;
    #3;
    chk("rs_err1_hready", 32'(HREADY), 32'd0);
    chk("rs_err1_hresp",  32'(HRESP),  32'd1);
    tick();
    #3;
    chk("rs_post_hready", 32'(HREADY), 32'd1);
    chk("rs_post_hresp",  32'(HRESP),  32'd0);
    chk("rs_post_hrdata", HRDATA,      BAD);
    HRESETn = 1'b1;
    HTRANS  = T_IDLE;
    tick();
    #3;
    chk("rs_idle_hready", 32'(HREADY), 32'd1);
    chk("rs_idle_hresp",  32'(HRESP),  32'd0);
    tick();

    // Slave 2 stalls indefinitely.
    HADDR  = 32'h8000_0000;
    HTRANS = T_NSEQ;
    tick();
    HADDR       = 32'h0000_0000;
    HTRANS      = T_IDLE;
    S_HREADYOUT = 4'b1011;
`ifdef AHBL_SPLITTER_WDT_EN
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("wd_stall%0d_hready", c), 32'(HREADY), 32'd0);
      chk($sformatf("wd_stall%0d_hresp", c),  32'(HRESP),  32'd0);
      tick();
    end
    S_HREADYOUT = 4'hF;
    #3;
    chk("wd_err1_hready", 32'(HREADY),  32'd0);
    chk("wd_err1_hresp",  32'(HRESP),   32'd1);
    chk("wd_err1_hrdata", HRDATA,       BAD);
    chk("wd_toflag",      32'(TO_FLAG), 32'd1);
    chk("wd_toidx",       32'(TO_IDX),  32'd2);
    tick();
    #3;
    chk("wd_err2_hready", 32'(HREADY), 32'd1);
    chk("wd_err2_hresp",  32'(HRESP),  32'd1);
    tick();
    #3;
    chk("wd_after_hready", 32'(HREADY),  32'd1);
    chk("wd_after_hresp",  32'(HRESP),   32'd0);
    chk("wd_flag_sticky",  32'(TO_FLAG), 32'd1);
    TO_CLR = 1'b1;
    tick();
    TO_CLR = 1'b0;
    #3;
    chk("wd_flag_clr", 32'(TO_FLAG), 32'd0);
    chk("wd_idx_hold", 32'(TO_IDX),  32'd2);
`else
    for (int c = 0; c < 6; c++) begin
      #3;
      chk($sformatf("nw_stall%0d_hready", c), 32'(HREADY), 32'd0);
      chk($sformatf("nw_stall%0d_toflag", c), 32'(TO_FLAG), 32'd0);
      tick();
    end
    S_HREADYOUT = 4'hF;
    #3;
    chk("nw_done_hready", 32'(HREADY), 32'd1);
    chk("nw_done_hresp",  32'(HRESP),  32'd0);
    chk("nw_done_hrdata", HRDATA,      32'hC2C2C2C2);
    chk("nw_toidx",       32'(TO_IDX), 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
